dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the MEM-stage data port.
- Accepts one load/store request per handshake, holds it for a programmable number of wait states, then returns a one-cycle response.
- Replaces the fixed-latency data_ram attachment, so the pipeline can be exercised against slower memory.
- Also provides a one-cycle-latency debug read port for the display logic.

Parameters:
- ADDR_W, 8: word-address width; depth = 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 0: extra cycles between acceptance and response, 0..15.

Ports:
- clk, input, 1: clock.
- resetn, input, 1: reset, synchronous, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request this cycle.
- req_wen, input, 4: byte write enables; 0 means read.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, byte lanes aligned to req_wen.
- resp_valid, output, 1: response pulse, one cycle.
- resp_rdata, output, 32: read data, or merged word for a write.
- resp_err, output, 1: address error; meaningful only with DMEM_ADDR_CHECK_EN.
- dbg_addr, input, 32: debug byte address.
- dbg_rdata, output, 32: debug read data, registered.

Behaviour:
- **Reset** (resetn=0 at a clk edge):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, dbg_rdata=0, wait counter=0.
  - Memory contents are not cleared.
  - A pending request is dropped with no response. A write already accepted stays committed.
- **Word index**: word index = req_addr[ADDR_W+1:2]; address bits [1:0] and bits above ADDR_W+1 are ignored, so the address wraps modulo depth.
- **States**: IDLE, WAIT, RESP.
- **req_ready** = (state==IDLE) | (state==RESP). Acceptance = req_valid & req_ready at a clk edge.
- **At acceptance edge**:
  - Each byte lane i with req_wen[i]=1 is written.
  - The merged post-write word is latched into a response register.
  - Read (req_wen=0): the latched word is the current contents.
  - Counter loads WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- **WAIT**: counter decrements each cycle; on reaching 1 the next state is RESP.
- **RESP**:
  - resp_valid=1 and resp_rdata=latched word for exactly one cycle.
  - If a new request is accepted in RESP, follow the acceptance rule. Otherwise return to IDLE.
- **Latency**: resp_valid rises 1+WAIT_CYCLES cycles after the acceptance edge.
- **Throughput**: with WAIT_CYCLES=0, back-to-back requests give one response per cycle.
- **Ordering**: a read accepted the cycle after a write to the same word returns the written data. No hazard exists because the write commits at acceptance.
- **Idle outputs**: resp_rdata holds its last value while resp_valid=0. req_valid while not ready is ignored; the requester must hold it.
- **Debug port**: dbg_rdata is sampled each edge from word dbg_addr[ADDR_W+1:2]. A same-edge write to that word returns the old value; the new value appears the next cycle.

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- **Defined**: an accepted request with any req_addr bit above ADDR_W+1 set, or with nonzero req_addr[1:0] while req_wen==4'hF or req_wen==0 (word access), is an error:
  - No byte is written.
  - Latched word = 0.
  - resp_err=1 alongside resp_valid.
  - resp_err=0 on every other cycle and for legal requests.
- **Undefined**: resp_err is tied 0, no checking is done, and the address wraps as above.

Test Plan:
- **Store then load**: WAIT_CYCLES=0; write 0x12345678 to 0x10 with wen=F, then read 0x10 the next cycle. Required: two consecutive resp_valid pulses; the read returns 0x12345678.
- **Byte merge**: preload word 0x10 with 0xAABBCCDD; write wen=4'b0010, wdata=0x0000EE00. Required: write response = 0xAABBEEDD, and a following read returns 0xAABBEEDD.
- **Wait states**: WAIT_CYCLES=3; read accepted at cycle t. Required: resp_valid only at t+4, req_ready=0 during t+1..t+3, and req_ready=1 at t+4.
- **Reset mid-operation**: WAIT_CYCLES=3; a write of 0x55 to 0x20 is accepted, then resetn=0 for one cycle before the response. Required: no resp_valid, state IDLE, req_ready=1; a later read of 0x20 returns 0x00000055.
- **Wrap and debug port**: ADDR_W=8; write 0xCAFEF00D to 0x404. Required: a read of 0x004 returns 0xCAFEF00D; dbg_addr=0x004 gives dbg_rdata=0xCAFEF00D one cycle later.
- **Address check** (DMEM_ADDR_CHECK_EN defined): write wen=F to 0x402. Required: resp_err=1 and rdata=0; word 0x400 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the MEM-stage data port.
// Accepts one load/store per handshake, commits writes at acceptance,
// holds for WAIT_CYCLES wait states, then pulses a one-cycle response
// carrying the merged (post-write) word. Also provides a registered,
// one-cycle-latency debug read port.
// Optional build macro: DMEM_ADDR_CHECK_EN enables address error checking
// (out-of-range or misaligned word accesses). When it is undefined,
// resp_err stays 0 and addresses simply wrap modulo the memory depth.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] dbg_idx;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic              accept;
    logic              addr_err;
    logic              mem_we;
    logic              unused_addr_bits;

    assign req_idx  = req_addr[ADDR_W+1:2];
    assign dbg_idx  = dbg_addr[ADDR_W+1:2];
    assign cur_word = mem[req_idx];

    // Bits outside the word index are deliberately ignored (address wraps).
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0],
                                dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    // A response slot frees up in the same cycle it is presented.
    assign req_ready = (state_q == IDLE) || (state_q == RESP);
    assign accept    = req_valid && req_ready;

    // Writes never land during reset, and an erroring request writes nothing.
    assign mem_we = accept && resetn && !addr_err;

`ifdef DMEM_ADDR_CHECK_EN
    // Flag out-of-range addresses and misaligned full-word accesses.
    always_comb begin
        addr_err = (|req_addr[31:ADDR_W+2]) ||
                   (((req_wen == 4'hF) || (req_wen == 4'h0)) && (|req_addr[1:0]));
    end
`else
    assign addr_err = 1'b0;
`endif

    // Post-write word: enabled byte lanes from wdata, the rest from memory.
    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (req_wen[i]) begin
                merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
        if (addr_err) begin
            merged = 32'h0;
        end
    end

    // Handshake FSM: next state, wait counter, latched response, outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
        dbg_rdata_d  = mem[dbg_idx];

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    word_d  = merged;
                    err_d   = addr_err;
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == RESP) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = word_d;
            resp_err_d   = err_d;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            dbg_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Latched response word; only meaningful after an acceptance.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    // Byte-lane memory write, committed at the acceptance edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wen[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (WAIT_CYCLES=0 and 3) driven
// with directed and random traffic, checked every cycle against a
// latency/array model, plus literal expectations for the key scenarios.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [1:0]  rstn = 2'b00;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_wen   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata [2];
    logic [1:0]  resp_err;
    logic [31:0] dbg_addr  [2];
    logic [31:0] dbg_rdata [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [31:0] mm [2][256];
    bit          busy  [2] = '{0, 0};
    int          due   [2] = '{0, 0};
    logic [31:0] pword [2];
    bit          perr  [2] = '{0, 0};
    bit          e_valid [2] = '{0, 0};
    logic [31:0] e_rdata [2] = '{32'h0, 32'h0};
    bit          e_err   [2] = '{0, 0};
    logic [31:0] e_dbg   [2] = '{32'h0, 32'h0};

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .resetn(rstn[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .dbg_addr(dbg_addr[0]), .dbg_rdata(dbg_rdata[0])
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .resetn(rstn[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .dbg_addr(dbg_addr[1]), .dbg_rdata(dbg_rdata[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: responses appear exactly W edges after the acceptance edge;
    // the slave is unavailable while a response is still outstanding.
    function automatic void model_step(int k);
        int          w;
        logic [7:0]  ri;
        logic [7:0]  di;
        logic [31:0] mw;
        bit          er;
        bit          acc;
        bit          show;
        w  = (k == 0) ? 0 : 3;
        ri = req_addr[k][9:2];
        di = dbg_addr[k][9:2];
        if (!rstn[k]) begin
            busy[k] = 0; e_valid[k] = 0; e_rdata[k] = 32'h0;
            e_err[k] = 0; e_dbg[k] = 32'h0;
            return;
        end
        acc      = req_valid[k] && !busy[k];
        show     = 0;
        e_dbg[k] = mm[k][di];
        if (busy[k] && due[k] == edge_n) begin
            show = 1; e_rdata[k] = pword[k]; e_err[k] = perr[k]; busy[k] = 0;
        end
        if (acc) begin
            er = 0;
`ifdef DMEM_ADDR_CHECK_EN
            er = (req_addr[k] >= 32'h400) ||
                 (((req_wen[k] == 4'hF) || (req_wen[k] == 4'h0)) && (req_addr[k][1:0] != 2'b00));
`endif
            mw = mm[k][ri];
            for (int i = 0; i < 4; i++)
                if (req_wen[k][i]) mw[8*i +: 8] = req_wdata[k][8*i +: 8];
            if (er) mw = 32'h0;
            else    mm[k][ri] = mw;
            if (w == 0) begin
                show = 1; e_rdata[k] = mw; e_err[k] = er;
            end else begin
                busy[k] = 1; due[k] = edge_n + w; pword[k] = mw; perr[k] = er;
            end
        end
        e_valid[k] = show;
        if (!show) e_err[k] = 0;
    endfunction

    // Advance the model on every edge, then compare all outputs.
    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 2; k++) model_step(k);
        #2;
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                string tag;
                tag = (k == 0) ? "w0" : "w3";
                chk({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'(e_valid[k]));
                chk({tag, "_req_ready"},  32'(req_ready[k]),  32'(!busy[k]));
                chk({tag, "_resp_rdata"}, resp_rdata[k], e_rdata[k]);
                chk({tag, "_resp_err"},   32'(resp_err[k]),   32'(e_err[k]));
                chk({tag, "_dbg_rdata"},  dbg_rdata[k], e_dbg[k]);
            end
        end
    end

    // Present a request at the next falling edge and hold it until ready.
    task automatic issue(input int k, input logic [3:0] wen, input logic [31:0] a,
                         input logic [31:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid[k] = 1'b1; req_wen[k] = wen; req_addr[k] = a; req_wdata[k] = d;
        while (!req_ready[k]) begin
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                n_cmp++; n_fail++;
                $display("FAIL ready_timeout: inst %0d never ready, required ready within 40 cycles", k);
                break;
            end
        end
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic init_mem(input int k);
        for (int i = 0; i < 256; i++)
            issue(k, 4'hF, 32'(i) << 2, $urandom);
        idle(k, 6);
    endtask

    task automatic directed0();
        issue(0, 4'hF, 32'h10, 32'h12345678);
        @(posedge clk); #3;
        chk("st_valid", 32'(resp_valid[0]), 32'h1);
        chk("st_rdata", resp_rdata[0], 32'h12345678);
        issue(0, 4'h0, 32'h10, 32'h0);
        @(posedge clk); #3;
        chk("ld_valid", 32'(resp_valid[0]), 32'h1);
        chk("ld_rdata", resp_rdata[0], 32'h12345678);
        issue(0, 4'hF, 32'h10, 32'hAABBCCDD);
        issue(0, 4'b0010, 32'h10, 32'h0000EE00);
        @(posedge clk); #3;
        chk("merge_wr", resp_rdata[0], 32'hAABBEEDD);
        issue(0, 4'h0, 32'h10, 32'h0);
        @(posedge clk); #3;
        chk("merge_rd", resp_rdata[0], 32'hAABBEEDD);
`ifndef DMEM_ADDR_CHECK_EN
        issue(0, 4'hF, 32'h404, 32'hCAFEF00D);
        issue(0, 4'h0, 32'h004, 32'h0);
        dbg_addr[0] = 32'h004;
        @(posedge clk); #3;
        chk("wrap_rd", resp_rdata[0], 32'hCAFEF00D);
        chk("wrap_dbg", dbg_rdata[0], 32'hCAFEF00D);
`else
        issue(0, 4'hF, 32'h000, 32'h11111111);
        issue(0, 4'hF, 32'h402, 32'hDEADBEEF);
        @(posedge clk); #3;
        chk("aerr_err", 32'(resp_err[0]), 32'h1);
        chk("aerr_rdata", resp_rdata[0], 32'h0);
        @(negedge clk);
        req_valid[0] = 1'b0; dbg_addr[0] = 32'h0;
        @(posedge clk); #3;
        chk("aerr_unchanged", dbg_rdata[0], 32'h11111111);
`endif
        idle(0, 3);
    endtask

    task automatic directed1();
        issue(1, 4'hF, 32'h20, 32'h00000055);
        @(negedge clk);
        req_valid[1] = 1'b0; rstn[1] = 1'b0;
        @(posedge clk); #3;
        chk("rst_valid", 32'(resp_valid[1]), 32'h0);
        chk("rst_ready", 32'(req_ready[1]), 32'h1);
        chk("rst_rdata", resp_rdata[1], 32'h0);
        @(negedge clk);
        rstn[1] = 1'b1;
        issue(1, 4'h0, 32'h20, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #3;
            chk("wait_ready", 32'(req_ready[1]), 32'h0);
            chk("wait_valid", 32'(resp_valid[1]), 32'h0);
            @(negedge clk);
            req_valid[1] = 1'b0;
        end
        @(posedge clk); #3;
        chk("wait_resp_valid", 32'(resp_valid[1]), 32'h1);
        chk("wait_resp_rdata", resp_rdata[1], 32'h00000055);
        chk("wait_resp_ready", 32'(req_ready[1]), 32'h1);
        idle(1, 3);
    endtask

    task automatic run_random(input int k, input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rstn[k]      = ($urandom_range(63) != 0);
            req_valid[k] = ($urandom_range(3) != 0);
            r = $urandom_range(3);
            req_wen[k]   = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom);
            req_addr[k]  = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(1023));
            req_wdata[k] = $urandom;
            dbg_addr[k]  = 32'($urandom_range(1023));
        end
        @(negedge clk);
        rstn[k] = 1'b1;
        idle(k, 8);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_wen[k] = 4'h0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0; dbg_addr[k] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("reset_valid", 32'(resp_valid[k]), 32'h0);
            chk("reset_rdata", resp_rdata[k], 32'h0);
            chk("reset_err",   32'(resp_err[k]), 32'h0);
            chk("reset_dbg",   dbg_rdata[k], 32'h0);
            chk("reset_ready", 32'(req_ready[k]), 32'h1);
        end
        @(negedge clk);
        rstn = 2'b11;
        fork
            init_mem(0);
            init_mem(1);
        join
        cmp_en = 1'b1;
        fork
            directed0();
            directed1();
        join
        fork
            run_random(0, 400);
            run_random(1, 400);
        join
        repeat (2) @(posedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 1000000");
        $fatal(1);
    end

endmodule
